// File: rtl/spi_pkg.sv
// spi_pkg: shared constants for the SPI responder slice.
//   - FSM state encodings used by spi_slave.
//   - SPI mode-0 edge selection (sample on rising sck, shift on falling sck).
//   - Minimum sck phase length, in CLK50MHZ cycles, the oversampler needs.
package spi_pkg;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACTIVE = 2'd1;
   localparam logic [1:0] FULL   = 2'd2;

   // Mode 0: CPOL=0 (sck idles low), CPHA=0 (sample on leading/rising edge).
   localparam bit CPOL           = 1'b0;
   localparam bit SAMPLE_ON_RISE = (CPOL == 1'b0);

   // Each sck phase must last at least this many system clocks (master DIV >= 6).
   localparam int unsigned MIN_OVERSAMPLE = 3;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: STAGES-deep synchronizer with registered rise/fall pulses.
// Ports:
//   CLK50MHZ  system clock
//   RST       synchronous active-high reset (clears the pulse outputs only)
//   din       asynchronous input pin
//   rise      one-cycle pulse after a synchronized 0->1 transition
//   fall      one-cycle pulse after a synchronized 1->0 transition
module spi_sync_edge
   import spi_pkg::*;
#(
   parameter int unsigned STAGES = 2
) (
   input  logic CLK50MHZ,
   input  logic RST,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              hist_q;

   // The chain keeps tracking the pin through reset so that a level already
   // present when RST releases never looks like a fresh edge.
   always_ff @(posedge CLK50MHZ) begin
      sync_q <= {sync_q[STAGES-2:0], din};
      hist_q <= sync_q[STAGES-1];
   end

   always_ff @(posedge CLK50MHZ) begin
      if (RST) begin
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= sync_q[STAGES-1] & ~hist_q;
         fall <= ~sync_q[STAGES-1] & hist_q;
      end
   end

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 responder, MSB first, oversampled in the CLK50MHZ domain.
// One WIDTH-bit frame is received per chip-select window; the reply word is
// latched from tx_data on the synchronized cs falling edge.
// Optional feature: define SPI_SLAVE_MISO_OE_EN to add the miso_oe output
// (high while a frame is in progress) for tristating a shared MISO line.
// Ports:
//   CLK50MHZ   system clock
//   RST        synchronous active-high reset
//   spi_sck    serial clock from master (idles low)
//   spi_cs     chip select from master (active low)
//   spi_mosi   master-out data
//   spi_miso   slave-out data (0 outside frames)
//   tx_data    reply word, sampled at frame start
//   rx_data    last complete received frame
//   rx_valid   one-cycle pulse: rx_data updated
//   frame_err  one-cycle pulse: frame aborted before WIDTH bits
//   busy       high while a frame is in progress
//   miso_oe    (SPI_SLAVE_MISO_OE_EN only) MISO output enable
module spi_slave
   import spi_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             CLK50MHZ,
   input  logic             RST,
   input  logic             spi_sck,
   input  logic             spi_cs,
   input  logic             spi_mosi,
   output logic             spi_miso,
   input  logic [WIDTH-1:0] tx_data,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             frame_err,
   output logic             busy
`ifdef SPI_SLAVE_MISO_OE_EN
   ,
   output logic             miso_oe
`endif
);

   localparam int unsigned     CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]   CNT_FULL = CW'(WIDTH);

   logic sck_rise, sck_fall, cs_rise, cs_fall;
   logic sample_ev, shift_ev;

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
      .CLK50MHZ (CLK50MHZ),
      .RST      (RST),
      .din      (spi_sck),
      .rise     (sck_rise),
      .fall     (sck_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
      .CLK50MHZ (CLK50MHZ),
      .RST      (RST),
      .din      (spi_cs),
      .rise     (cs_rise),
      .fall     (cs_fall)
   );

   assign sample_ev = SAMPLE_ON_RISE ? sck_rise : sck_fall;
   assign shift_ev  = SAMPLE_ON_RISE ? sck_fall : sck_rise;

   // mosi sees the same depth as the sck path (sync stages + registered edge)
   // so the bit presented with a sample pulse is the one on the pin at the edge.
   logic [SYNC_STAGES:0] mosi_dly_q;
   logic                 mosi_s;

   always_ff @(posedge CLK50MHZ) begin
      mosi_dly_q <= {mosi_dly_q[SYNC_STAGES-1:0], spi_mosi};
   end
   assign mosi_s = mosi_dly_q[SYNC_STAGES];

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] tx_q, tx_d;
   logic [WIDTH-1:0] rx_q, rx_d;
   logic [WIDTH-1:0] rx_data_q, rx_data_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic             miso_q, miso_d;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      rx_data_d = rx_data_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      miso_d    = miso_q;
      case (state_q)
         IDLE: begin
            miso_d = 1'b0;
            if (cs_fall) begin
               state_d = ACTIVE;
               tx_d    = tx_data;
               miso_d  = tx_data[WIDTH-1];
               cnt_d   = '0;
            end
         end
         ACTIVE: begin
            // cs rising takes priority over any sck edge in the same cycle.
            if (cs_rise) begin
               state_d = IDLE;
               miso_d  = 1'b0;
               if (cnt_q == CNT_FULL) begin
                  rx_data_d = rx_q;
                  valid_d   = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end else if (cnt_q == CNT_FULL) begin
               rx_data_d = rx_q;
               valid_d   = 1'b1;
               state_d   = FULL;
               miso_d    = 1'b0;
            end else if (sample_ev) begin
               rx_d  = {rx_q[WIDTH-2:0], mosi_s};
               cnt_d = cnt_q + CW'(1);
            end else if (shift_ev) begin
               // Rotate rather than shift: only the MSB is ever driven out.
               tx_d   = {tx_q[WIDTH-2:0], tx_q[WIDTH-1]};
               miso_d = tx_q[WIDTH-2];
            end
         end
         FULL: begin
            miso_d = 1'b0;
            if (cs_rise) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            miso_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK50MHZ) begin
      if (RST) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         tx_q      <= '0;
         rx_q      <= '0;
         rx_data_q <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         miso_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         rx_data_q <= rx_data_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         miso_q    <= miso_d;
      end
   end

   assign spi_miso  = miso_q;
   assign rx_data   = rx_data_q;
   assign rx_valid  = valid_q;
   assign frame_err = err_q;
   assign busy      = (state_q != IDLE);
`ifdef SPI_SLAVE_MISO_OE_EN
   assign miso_oe   = (state_q != IDLE);
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: self-checking bench for spi_slave (WIDTH=8, SYNC_STAGES=2).
// Received words are checked through an expected/observed queue pair.
module tb_spi_slave;
   import spi_pkg::*;

   localparam int unsigned W    = 8;
   localparam int unsigned SS   = 2;
   localparam int          HALF = MIN_OVERSAMPLE;

   logic         CLK50MHZ = 1'b0;
   logic         RST = 1'b1;
   logic         spi_sck = 1'b0;
   logic         spi_cs = 1'b1;
   logic         spi_mosi = 1'b0;
   logic         spi_miso;
   logic [W-1:0] tx_data = '0;
   logic [W-1:0] rx_data;
   logic         rx_valid;
   logic         frame_err;
   logic         busy;
`ifdef SPI_SLAVE_MISO_OE_EN
   logic         miso_oe;
   logic         oe_seen;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int valid_cnt = 0;
   int err_cnt   = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] obs_q[$];

   always #10 CLK50MHZ = ~CLK50MHZ;

   spi_slave #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
      .CLK50MHZ  (CLK50MHZ),
      .RST       (RST),
      .spi_sck   (spi_sck),
      .spi_cs    (spi_cs),
      .spi_mosi  (spi_mosi),
      .spi_miso  (spi_miso),
      .tx_data   (tx_data),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .busy      (busy)
`ifdef SPI_SLAVE_MISO_OE_EN
      ,
      .miso_oe   (miso_oe)
`endif
   );

   // Monitor: capture every delivered word and count pulse cycles.
   always @(negedge CLK50MHZ) begin
      if (rx_valid) begin
         obs_q.push_back(rx_data);
         valid_cnt++;
      end
      if (frame_err) err_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge CLK50MHZ);
   endtask

   // Master model: mode 0, mosi changes on falling sck, miso read late in the high phase.
   task automatic drive_frame(input logic [15:0] bits, input int nbits,
                              output logic [15:0] miso_bits, output logic busy_seen);
      miso_bits = '0;
      busy_seen = 1'b1;
      spi_cs    = 1'b0;
      spi_mosi  = bits[nbits-1];
      tick(2 * HALF);
      for (int i = 0; i < nbits; i++) begin
         spi_sck = 1'b1;
         tick(HALF);
         miso_bits[nbits-1-i] = spi_miso;
         busy_seen = busy_seen & busy;
`ifdef SPI_SLAVE_MISO_OE_EN
         oe_seen = oe_seen & miso_oe;
`endif
         spi_sck = 1'b0;
         if (i < nbits - 1) spi_mosi = bits[nbits-2-i];
         tick(HALF);
      end
      spi_cs = 1'b1;
   endtask

   task automatic sck_pulses(input int n);
      for (int i = 0; i < n; i++) begin
         spi_sck = 1'b1;
         tick(HALF);
         spi_sck = 1'b0;
         tick(HALF);
      end
   endtask

   task automatic wait_obs(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (obs_q.size() >= n) begin
            ok = 1'b1;
            break;
         end
         tick(1);
      end
   endtask

   task automatic check_next_word(input string name);
      bit           ok;
      logic [W-1:0] got, exp;
      wait_obs(1, ok);
      n_tests++;
      if (!ok || exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: no rx word observed (obs=%0d exp=%0d)", name, obs_q.size(),
                  exp_q.size());
      end else begin
         got = obs_q.pop_front();
         exp = exp_q.pop_front();
         if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: rx_data got %h expected %h", name, got, exp);
         end
      end
   endtask

   task automatic test_reset;
      n_tests += 5;
      if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
      if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
      if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b expected 0", spi_miso); end
   endtask

   task automatic test_basic;
      logic [15:0] mb;
      logic        bs;
      int          v0, e0;
      v0 = valid_cnt;
      e0 = err_cnt;
      tx_data = 8'hA5;
      exp_q.push_back(8'h3C);
      drive_frame(16'h003C, 8, mb, bs);
      tx_data = 8'h00;
      tick(4 * HALF);
      check_next_word("basic_rx");
      n_tests += 5;
      if (mb[7:0] !== 8'hA5) begin n_fail++; $display("FAIL basic_miso: got %h expected a5", mb[7:0]); end
      if (valid_cnt - v0 != 1) begin n_fail++; $display("FAIL basic_valid_count: got %0d expected 1", valid_cnt - v0); end
      if (err_cnt != e0) begin n_fail++; $display("FAIL basic_frame_err: got %0d pulses expected 0", err_cnt - e0); end
      if (bs !== 1'b1) begin n_fail++; $display("FAIL basic_busy_in_frame: got %b expected 1", bs); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
   endtask

   task automatic test_back_to_back;
      logic [15:0] mb1, mb2;
      logic        bs;
      logic        gap_busy;
      int          v0;
      v0 = valid_cnt;
      tx_data = 8'h0F;
      exp_q.push_back(8'hFF);
      drive_frame(16'h00FF, 8, mb1, bs);
      tx_data = 8'hF0;
      tick(4 * HALF);
      gap_busy = busy;
      exp_q.push_back(8'h00);
      drive_frame(16'h0000, 8, mb2, bs);
      tick(4 * HALF);
      check_next_word("b2b_first");
      check_next_word("b2b_second");
      n_tests += 4;
      if (gap_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_busy: got %b expected 0", gap_busy); end
      if (valid_cnt - v0 != 2) begin n_fail++; $display("FAIL b2b_valid_count: got %0d expected 2", valid_cnt - v0); end
      if (mb1[7:0] !== 8'h0F) begin n_fail++; $display("FAIL b2b_miso1: got %h expected 0f", mb1[7:0]); end
      if (mb2[7:0] !== 8'hF0) begin n_fail++; $display("FAIL b2b_miso2: got %h expected f0", mb2[7:0]); end
   endtask

   task automatic test_abort;
      logic [15:0] mb;
      logic        bs;
      int          v0, e0;
      v0 = valid_cnt;
      e0 = err_cnt;
      drive_frame(16'h0015, 5, mb, bs);
      tick(4 * HALF);
      n_tests += 3;
      if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL abort_frame_err: got %0d pulses expected 1", err_cnt - e0); end
      if (valid_cnt != v0) begin n_fail++; $display("FAIL abort_rx_valid: got %0d pulses expected 0", valid_cnt - v0); end
      if (rx_data !== 8'h00) begin n_fail++; $display("FAIL abort_rx_data: got %h expected 00", rx_data); end
   endtask

   task automatic test_overrun;
      logic [15:0] mb;
      logic [9:0]  exp_miso;
      logic        bs;
      int          v0;
      v0 = valid_cnt;
      exp_miso = {8'h96, 2'b00};
      tx_data = 8'h96;
      exp_q.push_back(8'hC3);
      drive_frame(16'h030F, 10, mb, bs);
      tick(4 * HALF);
      check_next_word("overrun_rx");
      n_tests += 2;
      if (mb[9:0] !== exp_miso) begin n_fail++; $display("FAIL overrun_miso: got %h expected %h", mb[9:0], exp_miso); end
      if (valid_cnt - v0 != 1) begin n_fail++; $display("FAIL overrun_valid_count: got %0d expected 1", valid_cnt - v0); end
   endtask

   task automatic test_rst_mid_frame;
      logic [15:0] mb;
      logic        bs;
      int          v0, e0;
      v0 = valid_cnt;
      e0 = err_cnt;
      tx_data  = 8'hFF;
      spi_cs   = 1'b0;
      spi_mosi = 1'b1;
      tick(2 * HALF);
      sck_pulses(4);
      RST = 1'b1;
      tick(3);
      n_tests += 4;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
      if (spi_miso !== 1'b0) begin n_fail++; $display("FAIL rst_miso: got %b expected 0", spi_miso); end
      if (rx_data !== 8'h00) begin n_fail++; $display("FAIL rst_rx_data: got %h expected 00", rx_data); end
      if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rx_valid: got %b expected 0", rx_valid); end
      RST = 1'b0;
      tick(2);
      sck_pulses(4);
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_stale_busy: got %b expected 0", busy); end
      spi_cs = 1'b1;
      tick(4 * HALF);
      n_tests += 2;
      if (valid_cnt != v0) begin n_fail++; $display("FAIL rst_no_valid: got %0d pulses expected 0", valid_cnt - v0); end
      if (err_cnt != e0) begin n_fail++; $display("FAIL rst_no_err: got %0d pulses expected 0", err_cnt - e0); end
      exp_q.push_back(8'h81);
      drive_frame(16'h0081, 8, mb, bs);
      tick(4 * HALF);
      check_next_word("rst_next_frame");
   endtask

`ifdef SPI_SLAVE_MISO_OE_EN
   task automatic test_miso_oe;
      logic [15:0] mb;
      logic        bs;
      n_tests++;
      if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL oe_idle: got %b expected 0", miso_oe); end
      oe_seen = 1'b1;
      tx_data = 8'h5A;
      exp_q.push_back(8'h42);
      drive_frame(16'h0042, 8, mb, bs);
      tick(SS + 2);
      n_tests += 2;
      if (oe_seen !== 1'b1) begin n_fail++; $display("FAIL oe_in_frame: got %b expected 1", oe_seen); end
      if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL oe_after_cs: got %b expected 0", miso_oe); end
      tick(4 * HALF);
      check_next_word("oe_rx");
   endtask
`endif

   initial begin
      RST = 1'b1;
      tick(6);
`ifdef SPI_SLAVE_MISO_OE_EN
      n_tests++;
      if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b expected 0", miso_oe); end
`endif
      test_reset();
      RST = 1'b0;
      tick(4);
      test_basic();
      test_back_to_back();
      test_abort();
      test_overrun();
      test_rst_mid_frame();
`ifdef SPI_SLAVE_MISO_OE_EN
      test_miso_oe();
`endif
      tick(4);
      n_tests++;
      if (obs_q.size() != 0) begin
         n_fail++;
         $display("FAIL stray_rx_words: got %0d unexpected words expected 0", obs_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
